// File: rtl/tanh_share_arbiter.sv
// Round-robin share of one combinational tanh unit between N_REQ requesters.
// Two registered stages, id-tagged results, whole pipeline freezes on downstream stall.

module tanh #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH:0]   TWO_X   = (WIDTH+1)'(32'h0002_0000);
  localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(32'h0001_0000);
  localparam logic [WIDTH:0]   HALF_X  = (WIDTH+1)'(32'h0000_8000);
  localparam logic [WIDTH:0]   LSB_X   = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ONE_Y   = WIDTH'(32'h0001_0000);
  localparam logic [WIDTH-1:0] HALF_Y  = WIDTH'(32'h0000_8000);
  localparam logic [WIDTH-1:0] QUART_Y = WIDTH'(32'h0000_4000);
  localparam logic [WIDTH-1:0] LSB_Y   = WIDTH'(1);

  logic             neg;
  logic [WIDTH:0]   mag;
  logic [WIDTH-1:0] r;

  // Odd-symmetric PWL on |x|: slope 1 up to 0.5, 1/2 up to 1.0, 1/4 up to 2.0, then 1.0.
  // The extra magnitude bit keeps |most-negative| representable.
  always_comb begin
    neg = x[WIDTH-1];
    mag = neg ? (~{x[WIDTH-1], x} + LSB_X) : {1'b0, x};
    if (mag >= TWO_X) begin
      r = ONE_Y;
    end else if (mag >= ONE_X) begin
      r = {2'b00, mag[WIDTH-1:2]} + HALF_Y;
    end else if (mag >= HALF_X) begin
      r = {1'b0, mag[WIDTH-1:1]} + QUART_Y;
    end else begin
      r = mag[WIDTH-1:0];
    end
    y = neg ? (~r + LSB_Y) : r;
  end

endmodule

module tanh_share_arbiter #(
  parameter int WIDTH = 24,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_valid,
  input  logic [N_REQ*WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [ID_W-1:0]        o_id,
  input  logic                   i_ready,
  output logic                   o_busy
);

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

  logic [ID_W-1:0]  last_q, last_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [ID_W-1:0]  s2_id_q, s2_id_d;

  logic             adv;
  logic             found;
  logic             gnt_fire;
  int               idx;
  logic [ID_W-1:0]  gnt_idx;
  logic [N_REQ-1:0] grant;
  logic [WIDTH-1:0] gnt_x;
  logic [WIDTH-1:0] tanh_y;

  tanh #(.WIDTH(WIDTH)) u_tanh (
    .x (s1_x_q),
    .y (tanh_y)
  );

  // Scan starts one past the last winner; rst_n gating keeps grants quiet during reset.
  always_comb begin
    adv     = ~(s2_valid_q & ~i_ready);
    found   = 1'b0;
    idx     = 0;
    gnt_idx = last_q;
    grant   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_q) + off) % N_REQ;
      if (!found && i_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (found && adv && rst_n) begin
      grant[gnt_idx] = 1'b1;
    end
    gnt_fire = |grant;
    gnt_x    = i_data[int'(gnt_idx)*WIDTH +: WIDTH];
  end

  always_comb begin
    last_d     = last_q;
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    if (adv) begin
      s1_valid_d = gnt_fire;
      if (gnt_fire) begin
        s1_x_d  = gnt_x;
        s1_id_d = gnt_idx;
        last_d  = gnt_idx;
      end
      s2_valid_d = s1_valid_q;
      s2_data_d  = tanh_y;
      s2_id_d    = s1_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= LAST_RST;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
    end else begin
      last_q     <= last_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign o_grant = grant;
  assign o_valid = s2_valid_q;
  assign o_data  = s2_data_q;
  assign o_id    = s2_id_q;
  assign o_busy  = s1_valid_q | s2_valid_q;

endmodule
